// File: rtl/div_seq_unit_pkg.sv
// Shared types for the iterative divider: operation codes, FSM states and
// small decode helpers used by the datapath and the bench.
package riscv_types;

    typedef enum logic [1:0] {
        DIVOP_DIV  = 2'b00,
        DIVOP_DIVU = 2'b01,
        DIVOP_REM  = 2'b10,
        DIVOP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_t;

    function automatic logic is_signed_op(input div_op_t op);
        return (op == DIVOP_DIV) || (op == DIVOP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return (op == DIVOP_REM) || (op == DIVOP_REMU);
    endfunction

endpackage

// File: rtl/div_seq_unit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_seq_unit_if #(
    parameter int XLEN = 32
);
    import riscv_types::*;

    logic            start;
    div_op_t         op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, op1, op2, flush,
        input  ready, done, result
    );

    modport slave (
        input  start, op, op1, op2, flush,
        output ready, done, result
    );

endinterface

// File: rtl/div_seq_unit_step.sv
// One restoring divide step: shift {rem, quo} left, try subtracting the
// divisor at XLEN+1 bits and keep the difference when no borrow occurs.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;

    // Trial subtraction; the top bit of the difference is the borrow.
    always_comb begin
        rem_sh = {rem_i, quo_i[XLEN-1]};
        trial  = rem_sh - {1'b0, dvsr_i};
        rem_o  = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        quo_o  = {quo_i[XLEN-2:0], ~trial[XLEN]};
    end

endmodule

// File: rtl/div_seq_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit. Operands are reduced to
// magnitudes on accept, XLEN restoring steps run in CALC, and FIX applies
// signs and selects quotient or remainder.
// Divide-by-zero and signed overflow are resolved from the operands, not
// from the iteration. Defining DIV_EARLY_OUT_EN returns those cases on the
// accept edge instead of running the full sequence.
//
// state | meaning
// IDLE  | ready, waiting for start
// CALC  | one restoring step per cycle, XLEN steps
// FIX   | sign correction, result register load, done next cycle
module div_seq_unit
    import riscv_types::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          reset,
    div_seq_unit_if.slave bus
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q, state_d;
    div_op_t         op_q, op_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] spec_res_q, spec_res_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    logic            op_signed;
    logic            a_neg, b_neg;
    logic            div_zero, sgn_ovf;
    logic [XLEN-1:0] op1_abs, op2_abs;
    logic [XLEN-1:0] spec_val;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] quo_fix, rem_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Operand conditioning and special-case results for the accept cycle.
    always_comb begin
        op_signed = is_signed_op(bus.op);
        a_neg     = op_signed & bus.op1[XLEN-1];
        b_neg     = op_signed & bus.op2[XLEN-1];
        op1_abs   = a_neg ? (-bus.op1) : bus.op1;
        op2_abs   = b_neg ? (-bus.op2) : bus.op2;
        div_zero  = (bus.op2 == '0);
        sgn_ovf   = op_signed && (bus.op1 == INT_MIN) && (bus.op2 == '1);
        if (is_rem_op(bus.op)) begin
            spec_val = div_zero ? bus.op1 : '0;
        end else begin
            spec_val = div_zero ? '1 : INT_MIN;
        end
        quo_fix = qneg_q ? (-quo_q) : quo_q;
        rem_fix = rneg_q ? (-rem_q) : rem_q;
    end

    // Next-state and datapath control; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        cnt_d      = cnt_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d       = bus.op;
                    quo_d      = op1_abs;
                    dvsr_d     = op2_abs;
                    rem_d      = '0;
                    cnt_d      = '0;
                    qneg_d     = a_neg ^ b_neg;
                    rneg_d     = a_neg;
                    special_d  = div_zero | sgn_ovf;
                    spec_res_d = spec_val;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero || sgn_ovf) begin
                        result_d = spec_val;
                        done_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (special_q) begin
                    result_d = spec_res_q;
                end else if (is_rem_op(op_q)) begin
                    result_d = rem_fix;
                end else begin
                    result_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= DIVOP_DIV;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            cnt_q      <= cnt_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Bench for div_seq_unit: directed and random ops, expected results queued
// at issue time and checked by an independent monitor on every done pulse.
module tb_div_seq_unit;
    import riscv_types::*;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } dir_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [31:0] last_exp;

    div_seq_unit_if #(.XLEN(32)) bus ();

    div_seq_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // RISC-V division semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            DIVOP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIVOP_REMU: return (b == 0) ? a : a % b;
            DIVOP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    function automatic int exp_lat(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 0) return 1;
        if ((op == DIVOP_DIV || op == DIVOP_REM) && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
`else
        if (op == DIVOP_DIV && a == 0 && b == 0) return 34;
`endif
        return 34;
    endfunction

    // Waits for ready at a falling edge, presents one start pulse and
    // optionally queues the expected response.
    task automatic issue(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit track, output int acc);
        int w;
        exp_t e;
        w = 0;
        while (!bus.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!bus.ready) begin
            errors++;
            $display("FAIL ready_wait: ready=%0b after %0d cycles, required 1", bus.ready, w);
        end
        bus.op    = op;
        bus.op1   = a;
        bus.op2   = b;
        bus.start = 1'b1;
        acc       = cyc;
        if (track) begin
            e.res = r;
            e.acc = cyc;
            e.lat = exp_lat(op, a, b);
            sb_q.push_back(e);
            last_exp = r;
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: result=%h at cycle %0d, required no done", bus.result, cyc);
            end else begin
                e = sb_q.pop_front();
                if (bus.result !== e.res) begin
                    errors++;
                    $display("FAIL result: got %h, required %h (accepted cycle %0d)", bus.result, e.res, e.acc);
                end
                checks++;
                if (cyc - e.acc != e.lat) begin
                    errors++;
                    $display("FAIL latency: got %0d, required %0d (accepted cycle %0d)", cyc - e.acc, e.lat, e.acc);
                end
            end
        end
    end

    initial begin
        dir_t dirs[12];
        int   acc;
        int   w;
        div_op_t rop;
        logic [31:0] ra, rb;
        int   sel;

        cyc       = 0;
        checks    = 0;
        errors    = 0;
        last_exp  = 32'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = DIVOP_DIV;
        bus.op1   = 32'd0;
        bus.op2   = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);

        dirs[0]  = '{DIVOP_DIVU, 32'd100, 32'd7, 32'd14};
        dirs[1]  = '{DIVOP_REMU, 32'd100, 32'd7, 32'd2};
        dirs[2]  = '{DIVOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
        dirs[3]  = '{DIVOP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
        dirs[4]  = '{DIVOP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1};
        dirs[5]  = '{DIVOP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF};
        dirs[6]  = '{DIVOP_REM, 32'd5, 32'd0, 32'd5};
        dirs[7]  = '{DIVOP_DIV, INT_MIN, 32'hFFFF_FFFF, INT_MIN};
        dirs[8]  = '{DIVOP_REM, INT_MIN, 32'hFFFF_FFFF, 32'd0};
        dirs[9]  = '{DIVOP_DIVU, INT_MIN, 32'hFFFF_FFFF, 32'd0};
        dirs[10] = '{DIVOP_REMU, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9};
        dirs[11] = '{DIVOP_DIV, INT_MIN, 32'd1, INT_MIN};

        // Back-to-back: each issue is presented in the done cycle of the previous one.
        foreach (dirs[i]) begin
            issue(dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].r, 1'b1, acc);
        end

        // Start pulses while busy must be ignored; operands keep changing.
        issue(DIVOP_DIVU, 32'd1000, 32'd33, 32'd30, 1'b1, acc);
        for (int i = 0; i < 20; i++) begin
            bus.start = 1'b1;
            bus.op    = div_op_t'($urandom_range(0, 3));
            bus.op1   = $urandom;
            bus.op2   = $urandom;
            @(negedge clk);
        end
        bus.start = 1'b0;

        // Flush in cycle 10 of an untracked op.
        issue(DIVOP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, acc);
        while (cyc < acc + 10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ready", 32'(bus.ready), 32'd1);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_result", bus.result, last_exp);
        repeat (40) @(negedge clk);
        check("flush_result_hold", bus.result, last_exp);
        issue(DIVOP_DIVU, 32'd9, 32'd3, 32'd3, 1'b1, acc);

        // Flush and start together while idle: start must lose.
        w = 0;
        while (!bus.ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        bus.op    = DIVOP_DIV;
        bus.op1   = 32'd5;
        bus.op2   = 32'd0;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_ready", 32'(bus.ready), 32'd1);
        repeat (3) @(negedge clk);

        // Reset in cycle 20 of an untracked op.
        issue(DIVOP_DIV, 32'd12345, 32'd17, 32'd0, 1'b0, acc);
        while (cyc < acc + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_exp = 32'd0;
        check("midreset_ready", 32'(bus.ready), 32'd1);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", bus.result, 32'd0);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            rop = div_op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: begin ra = INT_MIN; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 500); rb = $urandom_range(1, 20); end
                3: begin ra = -$urandom_range(0, 500); rb = $urandom_range(1, 20); end
                4: begin ra = $urandom_range(0, 500); rb = -$urandom_range(1, 20); end
                5: rb = $urandom_range(1, 255);
                default: ;
            endcase
            issue(rop, ra, rb, ref_div(rop, ra, rb), 1'b1, acc);
        end

        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_seq_unit.md
# div_seq_unit

Iterative RV32M divider/remainder controller for the core's execute stage. It sequences a single 33-bit subtract-and-restore step over XLEN cycles to produce DIV, DIVU, REM and REMU results. It accepts one operation at a time through a start/ready handshake, signals completion with a one-cycle `done` pulse, and can be killed by a pipeline flush. The ALU handles all single-cycle operations; this block owns only the multi-cycle divide path.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.

Ports:
- `clk`, input, 1: clock; all state updates on rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request; accepted only when `ready`=1.
- `op`, input, `div_op_t` (2 bits): operation, sampled on accept.
- `op1`, input, XLEN: dividend (rs1), sampled on accept.
- `op2`, input, XLEN: divisor (rs2), sampled on accept.
- `flush`, input, 1: abort current operation.
- `ready`, output, 1: unit idle and able to accept.
- `done`, output, 1: one-cycle pulse; `result` valid.
- `result`, output, XLEN: quotient or remainder; held until the next accept.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, with `start`=1 and `flush`=0:
  - Latch `op`.
  - Latch |op1| and |op2| for signed ops, raw values for unsigned ops.
  - Latch quotient sign = sign(op1) XOR sign(op2), and remainder sign = sign(op1), both signed ops only.
  - Clear the partial remainder and iteration counter, then go to CALC.
- CALC runs one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − divisor, computed at XLEN+1 bits.
  - If trial ≥ 0: rem = trial and quo[0] = 1. Otherwise quo[0] = 0.
  - The counter runs 0..XLEN−1. After the step at count XLEN−1, go to FIX.
- FIX:
  - Apply the sign: negate quo if the quotient sign is set, negate rem if the remainder sign is set.
  - Select quo for DIV/DIVU and rem for REM/REMU.
  - Register the selection into `result`, set `done` for the next cycle, and go to IDLE.
- Special cases always produce RISC-V results:
  - Divide by zero: quotient = all ones, remainder = op1.
  - Signed overflow (op1 = 0x8000_0000, op2 = 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
  - The datapath treats these explicitly. It does not rely on the iteration result.
- `flush`=1 in any state: go to IDLE on the next edge. Effects:
  - `done` stays 0; if `done` was already high in that cycle, it still clears at the next edge.
  - `result` is unchanged.
  - A `start` in the same cycle is ignored; flush wins.
- `start` while `ready`=0 is ignored; there is no queuing.
- All arithmetic is modulo 2^XLEN. Negation is two's complement. The trial subtraction is XLEN+1 bits so the borrow is the sign.

## Timing
Reset values:
- State is IDLE, so `ready`=1.
- `done`=0.
- `result`=0.
- Counter and internal registers are 0.

Latency:
- Normal operation: `done` is high exactly XLEN+2 cycles after the accept cycle (34 for XLEN=32). The accept cycle is cycle 0.
- `ready`=0 from cycle 1 through cycle XLEN+1.

Handshake rules:
- `ready` returns to 1 in the same cycle `done` is high.
- A new `start` in that cycle is accepted, giving back-to-back throughput of one op per XLEN+2 cycles.
- `done` is never high for two consecutive cycles unless there are two back-to-back early-out ops.

Reset mid-operation: behaves like flush, and additionally clears `result`.

## Configuration
Macro `DIV_EARLY_OUT_EN`:
- Defined: divide-by-zero and signed-overflow operations skip CALC/FIX. The result is registered on the accept edge and `done` is high in cycle 1; `ready` stays 1.
- Undefined: these operations take the full XLEN+2 latency and produce identical results.

## Structure
- Package `riscv_types` provides:
  - `div_op_t` (DIVOP_DIV=2'b00, DIVOP_DIVU=2'b01, DIVOP_REM=2'b10, DIVOP_REMU=2'b11).
  - `div_state_t` (IDLE, CALC, FIX).
- Sub-module `div_step`: purely combinational single restoring step. Inputs are rem, quo and divisor; outputs are next rem and next quo. It is instantiated once in `div_seq_unit`.

## Test plan
- DIVU 100 / 7: `result`=14, `done` at cycle 34. REMU 100 / 7: `result`=2.
- DIV −7 / 2: `result`=0xFFFF_FFFD (−3). REM −7 / 2: `result`=0xFFFF_FFFF (−1). REM 7 / −2: `result`=1.
- DIV 5 / 0: `result`=0xFFFF_FFFF. REM 5 / 0: `result`=5. DIV 0x8000_0000 / −1: `result`=0x8000_0000. REM of the same operands: `result`=0.
  - Latency is 1 cycle with `DIV_EARLY_OUT_EN` defined and 34 cycles without.
- `flush` at cycle 10 of DIVU 100 / 7:
  - No `done`, `ready`=1 at cycle 11, `result` keeps its prior value.
  - A following DIVU 9 / 3 then returns 3.
- Back-to-back:
  - Assert `start` in the `done` cycle of a prior op: accepted, second `done` 34 cycles later.
  - `start` pulses while busy are ignored.
- Reset asserted at cycle 20: `ready`=1, `done`=0 and `result`=0 on the next cycle.
